// File: rtl/id_pkg.sv
// Shared types and constants for the ID-entry front stage of the login path.
package id_pkg;

  localparam int ID_W   = 16;
  localparam int ADDR_W = 5;
  localparam int IDX_W  = 3;

  localparam logic [ID_W-1:0] EMPTY_ID = 16'hFFFF;

  typedef enum logic [3:0] {
    D1      = 4'd0,
    D2      = 4'd1,
    D3      = 4'd2,
    D4      = 4'd3,
    FETCH   = 4'd4,
    WAIT    = 4'd5,
    CATCH   = 4'd6,
    COMPARE = 4'd7,
    MATCHED = 4'd8,
    LOCKED  = 4'd9
  } state_t;

endpackage

// File: rtl/id_digit_collector.sv
// Assembles four switch nibbles into the entered ID, most significant digit first.
module id_digit_collector
  import id_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      digit,
  input  logic            load,
  input  logic [1:0]      pos,
  input  logic            clear,
  output logic [ID_W-1:0] id,
  output logic            complete
);

  assign complete = load && (pos == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      id <= '0;
    end else if (load) begin
      case (pos)
        2'd0:    id[15:12] <= digit;
        2'd1:    id[11:8]  <= digit;
        2'd2:    id[7:4]   <= digit;
        default: id[3:0]   <= digit;
      endcase
    end
  end

endmodule

// File: rtl/id_checking.sv
// ID entry, sequential ROM scan and failed-attempt lockout ahead of the password stage.
//
// state   | meaning
// D1..D4  | waiting for digit 1..4 of the user ID
// FETCH   | drive ROM address of entry idx
// WAIT    | ROM read latency countdown
// CATCH   | capture ROM read data
// COMPARE | compare captured entry against entered ID
// MATCHED | hit held for the password stage until log_out
// LOCKED  | too many failed entries; only rst leaves
module id_checking
  import id_pkg::*;
#(
  parameter int              NUM_IDS      = 8,
  parameter int              ROM_LAT      = 2,
  parameter int              MAX_ATTEMPTS = 3,
  parameter int              GUEST_IDX    = 0,
  parameter logic [ID_W-1:0] EMPTY_ID     = id_pkg::EMPTY_ID
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        iddigit,
  input  logic              identer,
  input  logic              log_out,
  input  logic [ID_W-1:0]   q_ID_ROM,
  output logic [ADDR_W-1:0] addr_ID_ROM,
  output logic              matchID,
  output logic [IDX_W-1:0]  intID,
  output logic              isGuest,
  output logic              id_fail,
  output logic              locked
);

  localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_IDS - 1);
  localparam logic [IDX_W-1:0] GUEST_SEL = IDX_W'(GUEST_IDX);
  localparam logic [CNT_W-1:0] WAIT_LOAD = (ROM_LAT > 0) ? CNT_W'(ROM_LAT - 1) : '0;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ID_W-1:0]   rom_data;
  logic [ATT_W-1:0]  attempts;
  logic [ID_W-1:0]   id_value;
  logic              id_complete;
  logic              digit_load;
  logic [1:0]        digit_pos;
  logic              hit, last_entry, fail_now, lock_now, id_clear;

  always_comb begin
    digit_load = 1'b0;
    digit_pos  = 2'd0;
    case (state)
      D1: begin digit_load = identer; digit_pos = 2'd0; end
      D2: begin digit_load = identer; digit_pos = 2'd1; end
      D3: begin digit_load = identer; digit_pos = 2'd2; end
      D4: begin digit_load = identer; digit_pos = 2'd3; end
      default: ;
    endcase
  end

  // Empty slots never match, so an entered FFFF can never log in.
  assign hit        = (rom_data == id_value) && (rom_data != EMPTY_ID);
  assign last_entry = (idx == LAST_IDX);
  assign fail_now   = (state == COMPARE) && !hit && last_entry;
  assign lock_now   = fail_now && (attempts == ATT_W'(MAX_ATTEMPTS - 1));
  assign id_clear   = (fail_now && !lock_now) || ((state == MATCHED) && log_out);

  id_digit_collector u_collector (
    .clk      (clk),
    .rst      (rst),
    .digit    (iddigit),
    .load     (digit_load),
    .pos      (digit_pos),
    .clear    (id_clear),
    .id       (id_value),
    .complete (id_complete)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= D1;
      idx         <= '0;
      wait_cnt    <= '0;
      rom_data    <= '0;
      attempts    <= '0;
      addr_ID_ROM <= '0;
      matchID     <= 1'b0;
      intID       <= '0;
      isGuest     <= 1'b0;
      id_fail     <= 1'b0;
      locked      <= 1'b0;
    end else begin
      id_fail <= 1'b0;
      case (state)
        D1: if (identer) state <= D2;
        D2: if (identer) state <= D3;
        D3: if (identer) state <= D4;
        D4: if (id_complete) begin
          idx   <= '0;
          state <= FETCH;
        end
        FETCH: begin
          addr_ID_ROM <= {{(ADDR_W-IDX_W){1'b0}}, idx};
          wait_cnt    <= WAIT_LOAD;
          state       <= (ROM_LAT == 0) ? CATCH : WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) state <= CATCH;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        CATCH: begin
          rom_data <= q_ID_ROM;
          state    <= COMPARE;
        end
        COMPARE: begin
          if (hit) begin
            matchID  <= 1'b1;
            intID    <= idx;
            isGuest  <= (idx == GUEST_SEL);
            attempts <= '0;
            state    <= MATCHED;
          end else if (!last_entry) begin
            idx   <= idx + 1'b1;
            state <= FETCH;
          end else begin
            id_fail  <= 1'b1;
            attempts <= attempts + 1'b1;
            if (lock_now) begin
              locked <= 1'b1;
              state  <= LOCKED;
            end else begin
              state  <= D1;
            end
          end
        end
        MATCHED: if (log_out) begin
          matchID <= 1'b0;
          intID   <= '0;
          isGuest <= 1'b0;
          state   <= D1;
        end
        LOCKED: state <= LOCKED;
        default: state <= D1;
      endcase
    end
  end

endmodule

// File: doc/id_checking.md
Name: id_checking

Overview:
- Front stage of the login path: collects a 4-digit user ID from toggle switches.
- Scans the ID ROM sequentially for a matching entry.
- On a hit, presents matchID / intID / isGuest to the password-checking stage directly downstream.
- Counts failed ID attempts, locks out after a limit, and clears its session when the downstream stage pulses log_out.

Parameters:
- NUM_IDS, 8, number of ROM entries scanned (addresses 0..NUM_IDS-1, max 8).
- ROM_LAT, 2, wait cycles between address update and data capture.
- MAX_ATTEMPTS, 3, consecutive failed ID entries before lockout.
- GUEST_IDX, 0, ROM index whose match sets isGuest.
- EMPTY_ID, 16'hFFFF, ROM value marking an unused slot (never matches).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-low reset.
- iddigit  in  4  digit value from toggle switches.
- identer  in  1  single-cycle pulse from the button shaper; latches iddigit.
- log_out  in  1  single-cycle pulse from the password stage; ends the session.
- q_ID_ROM  in  16  ID ROM read data.
- addr_ID_ROM  out  5  ID ROM address.
- matchID  out  1  high while a matched ID is held.
- intID  out  3  ROM index of the matched ID.
- isGuest  out  1  matched index == GUEST_IDX.
- id_fail  out  1  one-cycle pulse on a failed scan.
- locked  out  1  high after MAX_ATTEMPTS failures; cleared only by rst.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State -> D1; addr_ID_ROM, matchID, intID, isGuest, id_fail, locked, attempt count and ID register all -> 0.
  - Reset aborts any scan in progress.
- Digit entry, states D1..D4:
  - Each identer stores iddigit into ID[15:12], [11:8], [7:4], [3:0] respectively and advances one state.
  - With no pulse, the state holds.
- Scan: D4+identer at cycle T -> FETCH, entered with index k=0.
  - FETCH: addr_ID_ROM <= {2'b00,k}.
  - WAIT: ROM_LAT cycles, counted by an internal counter.
  - CATCH: capture q_ID_ROM into a data register.
  - COMPARE: hit if the data register == ID and the data register != EMPTY_ID.
  - Each entry takes 3+ROM_LAT cycles (5 at default).
- Hit on entry k (COMPARE at T+5+5k):
  - matchID=1, intID=k and isGuest=(k==GUEST_IDX) are visible at T+6+5k.
  - State -> MATCHED; attempt count -> 0.
- Miss on entry k < NUM_IDS-1: k++ and return to FETCH.
- Miss on the last entry:
  - id_fail is high for exactly one cycle, at T+6+5(NUM_IDS-1) (T+41 at default).
  - Attempt count increments.
  - If the count reaches MAX_ATTEMPTS: state -> LOCKED and locked=1. Otherwise: state -> D1 and the ID register clears.
- MATCHED:
  - Outputs hold and identer is ignored.
  - log_out -> matchID, intID and isGuest cleared on the next edge; state -> D1.
- LOCKED: all inputs are ignored except rst.
- identer received during FETCH/WAIT/CATCH/COMPARE/MATCHED/LOCKED is dropped, not queued.
- log_out outside MATCHED is ignored.
- log_out and identer together in MATCHED: log_out wins; the digit is dropped.
- Entered ID 16'hFFFF can never match.
- Unused state encodings -> D1 on the next edge.
- All outputs are registered; no combinational input-to-output path.

Decomposition:
- Shared package (id_pkg):
  - state encoding localparams: D1, D2, D3, D4, FETCH, WAIT, CATCH, COMPARE, MATCHED, LOCKED;
  - ID_W=16, ADDR_W=5, IDX_W=3;
  - EMPTY_ID.
- One natural sub-module, id_digit_collector:
  - the D1..D4 nibble shift/load logic plus a "complete" pulse;
  - the parent FSM owns the scan, compare and lockout.

Test Plan:
ROM contents for all scenarios: [0]=0000, [1]=9989, [2]=1234, [3..7]=FFFF.
- Enter 9,9,8,9 -> matchID=1, intID=1, isGuest=0 at T+11; addr_ID_ROM sequence 0,1; outputs hold for 50 cycles.
- Enter 0,0,0,0 -> matchID=1, intID=0, isGuest=1 at T+6; then log_out pulse -> all three 0 next cycle; a fresh entry of 1,2,3,4 matches intID=2 at T+16.
- Enter 5,5,5,5 -> addr walks 0..7; id_fail=1 only at T+41; matchID stays 0; next digit entry accepted.
- Enter F,F,F,F -> no match (empty slots skipped) -> id_fail at T+41.
- Three wrong IDs -> locked=1 after the third id_fail; a subsequent 9,9,8,9 is ignored; rst=0 for one cycle -> locked=0 and entry works again.
- rst=0 at T+8 mid-scan -> all outputs 0 and state D1 next edge; identer pulses 1 cycle apart during the scan are dropped; log_out+identer coincident in MATCHED -> session cleared and digit not stored.
